// File: rtl/pll_reconfig_pkg.sv
// Shared types and reset constants for the PLL scale-counter reconfiguration controller.
package pll_reconfig_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BYPASS = 2'd1,
        MODE_EVEN   = 2'd2,
        MODE_ODD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int unsigned RST_HIGH = 1;
    localparam int unsigned RST_LOW  = 1;
    localparam int unsigned RST_INIT = 1;
    localparam mode_e       RST_MODE = MODE_OFF;

endpackage

// File: rtl/pll_cntr_cfg_bank.sv
// Shadow + active settings for one scale-down counter; shadow is exposed only when
// PLL_RECONFIG_READBACK_EN is defined.
module pll_cntr_cfg_bank
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             commit,
    input  logic [CNT_W-1:0] wr_high,
    input  logic [CNT_W-1:0] wr_low,
    input  logic [CNT_W-1:0] wr_init,
    input  logic [1:0]       wr_mode,
`ifdef PLL_RECONFIG_READBACK_EN
    output logic [CNT_W-1:0] shd_high,
    output logic [CNT_W-1:0] shd_low,
    output logic [CNT_W-1:0] shd_init,
    output logic [1:0]       shd_mode,
`endif
    output logic [CNT_W-1:0] act_high,
    output logic [CNT_W-1:0] act_low,
    output logic [CNT_W-1:0] act_init,
    output logic [1:0]       act_mode
);

`ifndef PLL_RECONFIG_READBACK_EN
    logic [CNT_W-1:0] shd_high;
    logic [CNT_W-1:0] shd_low;
    logic [CNT_W-1:0] shd_init;
    logic [1:0]       shd_mode;
`endif

    // Writes and commit never coincide: writes occur only in IDLE, commit only leaving HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            shd_high <= CNT_W'(RST_HIGH);
            shd_low  <= CNT_W'(RST_LOW);
            shd_init <= CNT_W'(RST_INIT);
            shd_mode <= RST_MODE;
            act_high <= CNT_W'(RST_HIGH);
            act_low  <= CNT_W'(RST_LOW);
            act_init <= CNT_W'(RST_INIT);
            act_mode <= RST_MODE;
        end else begin
            if (wr_en) begin
                shd_high <= wr_high;
                shd_low  <= wr_low;
                shd_init <= wr_init;
                shd_mode <= wr_mode;
            end
            if (commit) begin
                act_high <= shd_high;
                act_low  <= shd_low;
                act_init <= shd_init;
                act_mode <= shd_mode;
            end
        end
    end

endmodule

// File: rtl/pll_cntr_reconfig.sv
// PLL scale-counter reconfiguration controller: shadow writes, held-reset atomic commit.
// Optional PLL_RECONFIG_READBACK_EN adds a registered shadow/active readback port.
module pll_cntr_reconfig
    import pll_reconfig_pkg::*;
#(
    parameter int unsigned NUM_CNTR    = 10,
    parameter int unsigned CNT_W       = 9,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(NUM_CNTR)-1:0] wr_idx,
    input  logic [CNT_W-1:0]            wr_high,
    input  logic [CNT_W-1:0]            wr_low,
    input  logic [CNT_W-1:0]            wr_init,
    input  logic [1:0]                  wr_mode,
    output logic                        wr_err,
    input  logic                        apply_req,
    output logic                        apply_busy,
    output logic                        apply_done,
    output logic                        cntr_reset,
`ifdef PLL_RECONFIG_READBACK_EN
    input  logic [$clog2(NUM_CNTR)-1:0] rd_idx,
    input  logic                        rd_shadow,
    output logic [CNT_W-1:0]            rd_high,
    output logic [CNT_W-1:0]            rd_low,
    output logic [CNT_W-1:0]            rd_init,
    output logic [1:0]                  rd_mode,
`endif
    output logic [NUM_CNTR*CNT_W-1:0]   cntr_high,
    output logic [NUM_CNTR*CNT_W-1:0]   cntr_low,
    output logic [NUM_CNTR*CNT_W-1:0]   cntr_init,
    output logic [NUM_CNTR*2-1:0]       cntr_mode
);

    localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

    state_e          state_q;
    state_e          state_d;
    logic [HC_W-1:0] hold_cnt;
    logic            wr_acc_c;
    logic            wr_legal_c;
    logic            commit_c;
    logic            ready_d;
    logic            err_d;
    logic            busy_d;
    logic            done_d;
    logic            creset_d;

    logic [CNT_W-1:0] act_high [NUM_CNTR];
    logic [CNT_W-1:0] act_low  [NUM_CNTR];
    logic [CNT_W-1:0] act_init [NUM_CNTR];
    logic [1:0]       act_mode [NUM_CNTR];

    // wr_ready is only high in IDLE, so it doubles as the write gate.
    assign wr_acc_c   = wr_valid && wr_ready;
    assign wr_legal_c = (32'(wr_idx) < NUM_CNTR) &&
                        ((wr_mode == MODE_OFF) || (wr_mode == MODE_BYPASS) ||
                         ((wr_high != '0) && (wr_low != '0) && (wr_init != '0)));
    assign commit_c   = (state_q == ST_HOLD) && (state_d == ST_COMMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_cnt   <= '0;
            wr_ready   <= 1'b0;
            wr_err     <= 1'b0;
            apply_busy <= 1'b0;
            apply_done <= 1'b0;
            cntr_reset <= 1'b1;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && (state_d == ST_HOLD)) begin
                hold_cnt <= HC_W'(HOLD_CYCLES);
            end else if ((state_q == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - HC_W'(1);
            end
            wr_ready   <= ready_d;
            wr_err     <= err_d;
            apply_busy <= busy_d;
            apply_done <= done_d;
            cntr_reset <= creset_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (apply_req) state_d = ST_HOLD;
            ST_HOLD:   if (hold_cnt == HC_W'(1)) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        creset_d = 1'b0;
        err_d    = wr_acc_c && !wr_legal_c;
        case (state_d)
            ST_IDLE:   ready_d = 1'b1;
            ST_HOLD,
            ST_COMMIT: begin
                busy_d   = 1'b1;
                creset_d = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef PLL_RECONFIG_READBACK_EN
    logic [CNT_W-1:0] shd_high [NUM_CNTR];
    logic [CNT_W-1:0] shd_low  [NUM_CNTR];
    logic [CNT_W-1:0] shd_init [NUM_CNTR];
    logic [1:0]       shd_mode [NUM_CNTR];
`endif

    for (genvar i = 0; i < int'(NUM_CNTR); i++) begin : g_bank
        pll_cntr_cfg_bank #(.CNT_W(CNT_W)) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (wr_acc_c && wr_legal_c && (32'(wr_idx) == 32'(i))),
            .commit   (commit_c),
            .wr_high  (wr_high),
            .wr_low   (wr_low),
            .wr_init  (wr_init),
            .wr_mode  (wr_mode),
`ifdef PLL_RECONFIG_READBACK_EN
            .shd_high (shd_high[i]),
            .shd_low  (shd_low[i]),
            .shd_init (shd_init[i]),
            .shd_mode (shd_mode[i]),
`endif
            .act_high (act_high[i]),
            .act_low  (act_low[i]),
            .act_init (act_init[i]),
            .act_mode (act_mode[i])
        );
        assign cntr_high[i*CNT_W +: CNT_W] = act_high[i];
        assign cntr_low[i*CNT_W +: CNT_W]  = act_low[i];
        assign cntr_init[i*CNT_W +: CNT_W] = act_init[i];
        assign cntr_mode[i*2 +: 2]         = act_mode[i];
    end

`ifdef PLL_RECONFIG_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset || (32'(rd_idx) >= NUM_CNTR)) begin
            rd_high <= '0;
            rd_low  <= '0;
            rd_init <= '0;
            rd_mode <= '0;
        end else if (rd_shadow) begin
            rd_high <= shd_high[rd_idx];
            rd_low  <= shd_low[rd_idx];
            rd_init <= shd_init[rd_idx];
            rd_mode <= shd_mode[rd_idx];
        end else begin
            rd_high <= act_high[rd_idx];
            rd_low  <= act_low[rd_idx];
            rd_init <= act_init[rd_idx];
            rd_mode <= act_mode[rd_idx];
        end
    end
`endif

endmodule
